// File: rtl/conv_window_gen_pkg.sv
// Shared definitions for the convolution window generator and its consumer.
// win_idx() fixes the packed window layout used by ConvLayer_calc.
package conv_window_gen_pkg;

  localparam int DEF_KERNEL = 3;
  localparam int DEF_N      = 4;
  localparam int WIN_W      = DEF_KERNEL * DEF_KERNEL * DEF_N;

  // Ceiling log2, clamped to 1 so single-entry dimensions still get a counter bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int win_bits(input int k, input int n);
    return k * k * n;
  endfunction

  function automatic int win_idx(input int r, input int c, input int k);
    return r * k + c;
  endfunction

endpackage

// File: rtl/conv_window_gen_if.sv
// Pixel-in / window-out bus of conv_window_gen.
// win_last is only present when CONV_WIN_LAST_EN is defined.
interface conv_window_gen_if #(
  parameter int N     = conv_window_gen_pkg::DEF_N,
  parameter int WIN_W = conv_window_gen_pkg::WIN_W
);
  logic [N-1:0]     pix_in;
  logic             pix_valid;
  logic             sof;
  logic [WIN_W-1:0] data2conv;
  logic             en_out;
`ifdef CONV_WIN_LAST_EN
  logic             win_last;

  modport master (output pix_in, pix_valid, sof,
                  input  data2conv, en_out, win_last);
  modport slave  (input  pix_in, pix_valid, sof,
                  output data2conv, en_out, win_last);
`else
  modport master (output pix_in, pix_valid, sof,
                  input  data2conv, en_out);
  modport slave  (input  pix_in, pix_valid, sof,
                  output data2conv, en_out);
`endif
endinterface

// File: rtl/conv_line_buf.sv
// One image line of pixel storage; combinational read of the addressed column
// so the old value is seen in the same cycle it is overwritten.
module conv_line_buf #(
  parameter int DEPTH = 8,
  parameter int W     = 4,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  assign rdata_o = mem_q[addr_i];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/conv_window_gen.sv
// Raster pixel stream to packed KERNEL x KERNEL "valid" windows, 1 clk latency.
// Optional win_last output enabled by CONV_WIN_LAST_EN.
module conv_window_gen
  import conv_window_gen_pkg::*;
#(
  parameter int KERNEL = 3,
  parameter int N      = 4,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8
) (
  input logic               clk,
  input logic               rst,
  conv_window_gen_if.slave  bus
);

  localparam int CW = clog2(IMG_W);
  localparam int RW = clog2(IMG_H);
  localparam int WW = win_bits(KERNEL, N);

  logic [CW-1:0] col_q, col_d, col_eff;
  logic [RW-1:0] row_q, row_d, row_eff;
  logic          gate;
  logic          en_q;
  logic [WW-1:0] data_q, data_d;
  logic [N-1:0]  new_col [KERNEL];
  logic [N-1:0]  win_q   [KERNEL][KERNEL];
  logic [N-1:0]  win_d   [KERNEL][KERNEL];

  // sof overrides the counters so the accepted pixel is (0,0).
  always_comb begin
    col_eff = bus.sof ? '0 : col_q;
    row_eff = bus.sof ? '0 : row_q;
    gate    = (col_eff >= CW'(KERNEL - 1)) && (row_eff >= RW'(KERNEL - 1));
    col_d   = col_q;
    row_d   = row_q;
    if (bus.pix_valid) begin
      if (col_eff == CW'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (row_eff == RW'(IMG_H - 1)) ? '0 : row_eff + RW'(1);
      end else begin
        col_d = col_eff + CW'(1);
        row_d = row_eff;
      end
    end
  end

  assign new_col[KERNEL-1] = bus.pix_in;

  // Buffer gi holds line row-1-gi and feeds window row KERNEL-2-gi; it is
  // written with whatever the row below it just read.
  generate
    for (genvar gi = 0; gi < KERNEL - 1; gi++) begin : g_line
      conv_line_buf #(
        .DEPTH (IMG_W),
        .W     (N),
        .AW    (CW)
      ) u_line (
        .clk     (clk),
        .rst     (rst),
        .we_i    (bus.pix_valid),
        .addr_i  (col_eff),
        .wdata_i (new_col[KERNEL-1-gi]),
        .rdata_o (new_col[KERNEL-2-gi])
      );
    end
  endgenerate

  generate
    for (genvar gr = 0; gr < KERNEL; gr++) begin : g_row
      for (genvar gc = 0; gc < KERNEL; gc++) begin : g_col
        if (gc < KERNEL - 1) begin : g_shift
          assign win_d[gr][gc] = win_q[gr][gc+1];
        end else begin : g_new
          assign win_d[gr][gc] = new_col[gr];
        end
        assign data_d[win_idx(gr, gc, KERNEL)*N +: N] = win_d[gr][gc];
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q  <= '0;
      row_q  <= '0;
      en_q   <= 1'b0;
      data_q <= '0;
      win_q  <= '{default: '0};
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      en_q  <= bus.pix_valid && gate;
      if (bus.pix_valid) begin
        win_q <= win_d;
      end
      // data2conv only moves on a full window, so it holds between pulses.
      if (bus.pix_valid && gate) begin
        data_q <= data_d;
      end
    end
  end

  assign bus.data2conv = data_q;
  assign bus.en_out    = en_q;

`ifdef CONV_WIN_LAST_EN
  logic last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b0;
    end else begin
      last_q <= bus.pix_valid && gate &&
                (row_eff == RW'(IMG_H - 1)) && (col_eff == CW'(IMG_W - 1));
    end
  end

  assign bus.win_last = last_q;
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen: 3x3 windows on a 5x4 image plus a 1x1 instance.
module tb_conv_window_gen;
  import conv_window_gen_pkg::*;

  localparam int K  = 3;
  localparam int NW = 4;
  localparam int W  = 5;
  localparam int H  = 4;
  localparam int WW = K * K * NW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv_window_gen_if #(.N(NW), .WIN_W(WW)) bus ();
  conv_window_gen_if #(.N(NW), .WIN_W(NW)) bus1 ();

  conv_window_gen #(.KERNEL(K), .N(NW), .IMG_W(W), .IMG_H(H)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  conv_window_gen #(.KERNEL(1), .N(NW), .IMG_W(2), .IMG_H(2)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  typedef struct {
    int            pix_idx;
    logic [WW-1:0] data;
    logic          last;
  } win_vec_t;

  win_vec_t      vec [6];
  int            errors = 0;
  int            checks = 0;
  logic [WW-1:0] last_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int slot_of(input int idx);
    for (int i = 0; i < 6; i++) begin
      if (vec[i].pix_idx == idx) return i;
    end
    return -1;
  endfunction

  // One clock on the main DUT; idx is the pixel position within the frame.
  task automatic pix_cycle(input logic valid, input logic s, input logic [NW-1:0] v,
                           input int idx, input string tag);
    int slot;
    @(negedge clk);
    bus.pix_valid = valid;
    bus.sof       = s;
    bus.pix_in    = v;
    @(posedge clk);
    #1;
    slot = valid ? slot_of(idx) : -1;
    check({tag, " en_out"}, 64'(bus.en_out), 64'(slot >= 0));
    if (slot >= 0) begin
      check({tag, " data2conv"}, 64'(bus.data2conv), 64'(vec[slot].data));
      last_data = vec[slot].data;
      $display("%s: window %0d after pixel %0d data2conv=%h", tag, slot, idx, bus.data2conv);
    end else begin
      check({tag, " hold"}, 64'(bus.data2conv), 64'(last_data));
    end
`ifdef CONV_WIN_LAST_EN
    check({tag, " win_last"}, 64'(bus.win_last), 64'((slot >= 0) ? vec[slot].last : 1'b0));
`endif
  endtask

  task automatic frame(input bit toggle, input bit with_sof, input string tag);
    for (int idx = 0; idx < W * H; idx++) begin
      pix_cycle(1'b1, with_sof && idx == 0, NW'(idx % 16), idx, tag);
      if (toggle) pix_cycle(1'b0, 1'b1, 4'hF, -1, tag);
    end
  endtask

  initial begin
    vec[0] = '{12, 36'hCBA765210, 1'b0};
    vec[1] = '{13, 36'hDCB876321, 1'b0};
    vec[2] = '{14, 36'hEDC987432, 1'b0};
    vec[3] = '{17, 36'h10FCBA765, 1'b0};
    vec[4] = '{18, 36'h210DCB876, 1'b0};
    vec[5] = '{19, 36'h321EDC987, 1'b1};

    bus.pix_valid  = 1'b0;
    bus.sof        = 1'b0;
    bus.pix_in     = '0;
    bus1.pix_valid = 1'b0;
    bus1.sof       = 1'b0;
    bus1.pix_in    = '0;
    last_data      = '0;

    #2;
    check("reset en_out", 64'(bus.en_out), 64'(0));
    check("reset data2conv", 64'(bus.data2conv), 64'(0));
    check("reset k1 en_out", 64'(bus1.en_out), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    // Two back-to-back frames, second one via row wrap rather than sof.
    frame(1'b0, 1'b1, "cont1");
    frame(1'b0, 1'b0, "cont2");
    pix_cycle(1'b0, 1'b0, 4'h0, -1, "idle");

    // Half-rate input; idle cycles carry sof=1 which must be ignored.
    frame(1'b1, 1'b0, "toggle");

    // Restart mid-frame with sof after 7 pixels.
    for (int idx = 0; idx < 7; idx++) pix_cycle(1'b1, 1'b0, NW'(idx), idx, "presof");
    frame(1'b0, 1'b1, "sof");
    pix_cycle(1'b0, 1'b0, 4'h0, -1, "idle");

    // Asynchronous reset after 9 pixels of a frame.
    for (int idx = 0; idx < 9; idx++) pix_cycle(1'b1, 1'b0, NW'(idx), idx, "prerst");
    @(negedge clk);
    bus.pix_valid = 1'b0;
    #1;
    check("pre-rst data2conv", 64'(bus.data2conv), 64'(vec[5].data));
    rst = 1'b1;
    #1;
    check("async rst data2conv", 64'(bus.data2conv), 64'(0));
    check("async rst en_out", 64'(bus.en_out), 64'(0));
    last_data = '0;
    @(negedge clk);
    rst = 1'b0;
    frame(1'b0, 1'b0, "afterrst");
    pix_cycle(1'b0, 1'b0, 4'h0, -1, "idle");

    // KERNEL=1 instance: every accepted pixel is a window.
    for (int i = 0; i < 4; i++) begin
      logic [NW-1:0] v;
      v = NW'(3 + 5 * i);
      @(negedge clk);
      bus1.pix_valid = 1'b1;
      bus1.pix_in    = v;
      @(posedge clk);
      #1;
      check("k1 en_out", 64'(bus1.en_out), 64'(1));
      check("k1 data2conv", 64'(bus1.data2conv), 64'(v));
      $display("k1: pixel %0d data2conv=%h", i, bus1.data2conv);
      @(negedge clk);
      bus1.pix_valid = 1'b0;
      bus1.pix_in    = 4'hE;
      @(posedge clk);
      #1;
      check("k1 idle en_out", 64'(bus1.en_out), 64'(0));
      check("k1 idle hold", 64'(bus1.data2conv), 64'(v));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
- Producer side of the convolution datapath. Turns a raster-order pixel stream into packed KERNEL x KERNEL windows on the `data2conv`/`en_in` interface that `ConvLayer_calc` consumes.
- Uses KERNEL-1 line buffers plus a KERNEL x KERNEL window register.
- Emits only full windows: "valid" convolution, no padding.
- Sits between the feature-map source and `ConvLayer_calc`.

Parameters:
- KERNEL, 3, window side; legal values 1/3/5/7.
- N, 4, pixel data width.
- IMG_W, 8, image width in pixels; must be >= KERNEL.
- IMG_H, 8, image height in lines; must be >= KERNEL.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- pix_in  in  N  input pixel, raster order (left to right, top to bottom).
- pix_valid  in  1  pix_in valid this cycle; there is no backpressure.
- sof  in  1  start of frame; qualified by pix_valid; marks pixel (0,0).
- data2conv  out  KERNEL*KERNEL*N  packed window; element i = r*KERNEL+c at bits [i*N +: N].
- en_out  out  1  data2conv valid; connects to `ConvLayer_calc` en_in.
- win_last  out  1  last window of frame; present only with the optional feature.

Behaviour:
- Reset (async, rst=1):
  - col_cnt, row_cnt, line buffers, window register, data2conv and en_out all go to 0.
  - Reset mid-frame discards the partial frame. The first pixel after reset is treated as (0,0) whether or not sof is set.
- Acceptance: a pixel is accepted only on a cycle with pix_valid=1. With pix_valid=0 nothing shifts, counters hold, en_out=0 and data2conv holds its last value.
- Counters:
  - col_cnt runs 0..IMG_W-1 and wraps to 0 while incrementing row_cnt.
  - row_cnt runs 0..IMG_H-1 and wraps to 0 at end of frame.
  - Counter width is clog2 of the respective dimension, minimum 1.
- sof: pix_valid=1 with sof=1 forces the accepted pixel to (0,0) regardless of the counters, then counting continues from (0,1). sof with pix_valid=0 is ignored.
- Line buffers:
  - Buffer k holds line row_cnt-1-k at each column.
  - On an accept at column c, buffer reads at c feed the window's new column, then write back shifted: buf0 <= pix_in, buf(k) <= buf(k-1).
  - Contents from the previous frame are stale but are masked by the row gating below.
- Window register:
  - On each accept, shift left by one column. The new rightmost column (c=KERNEL-1) is top-to-bottom: buf(KERNEL-2) ... buf0, pix_in.
  - Window row r=0 is the oldest (top) line; column c=0 is the leftmost.
- Output valid:
  - en_out=1 exactly one cycle after an accept where col_cnt >= KERNEL-1 and row_cnt >= KERNEL-1 (before the counter update).
  - data2conv updates in that same cycle. Latency is 1 clk from the completing pixel.
  - Windows never span a line boundary, because the column gate blocks them.
- Frame output count: (IMG_W-KERNEL+1)*(IMG_H-KERNEL+1) en_out pulses.
- KERNEL=1: no line buffers; data2conv = pix_in registered; en_out = pix_valid delayed one cycle.
- Back-to-back frames with no gap are supported; row_cnt wrap and sof are equivalent.

Optional Feature:
- Macro: CONV_WIN_LAST_EN.
- Defined: the win_last output exists and is registered alongside en_out. It is 1 only on the window completed by pixel (IMG_H-1, IMG_W-1), and resets to 0.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Shared package/header: a clog2 function, and a localparam for the window bit width KERNEL*KERNEL*N.
- The packing index macro/function `win_idx(r,c)=r*KERNEL+c` also goes there, so `ConvLayer_calc` and the bench use the same layout.
- Sub-module `conv_line_buf`: one line of IMG_W x N storage with read-before-write at an address, instantiated KERNEL-1 times via generate.

Test Plan:
- KERNEL=3, N=4, IMG_W=5, IMG_H=4, pixel value (r*5+c) mod 16, pix_valid continuous:
  - First en_out comes 1 clk after pixel 12 is accepted.
  - data2conv nibbles i=0..8 = 0,1,2,5,6,7,10,11,12.
  - Exactly 6 pulses per frame.
- Same setup with pix_valid toggling 1/0 every cycle: identical window sequence; en_out never high on consecutive cycles; data2conv stable between pulses.
- Assert sof at pixel index 7 of the first frame, then a full frame: windows are computed relative to the new (0,0); the first window after sof appears after the 13th pixel counted from sof.
- Pulse rst for one cycle mid-frame (after 9 pixels):
  - data2conv=0 and en_out=0 immediately (async).
  - Restarted frame gives the same 6 windows as scenario 1.
- KERNEL=1, IMG_W=IMG_H=2: four en_out pulses, each data2conv equal to the pixel from one clk earlier.
- With CONV_WIN_LAST_EN: win_last=1 only on the 6th window (nibbles 7,8,9,12,13,14,1,2,3, where 17 mod 16 and 18 mod 16 wrap); 0 otherwise.
